// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus transaction types, arbiter states and bus widths
package bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } tsize_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        BUSY    = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - master-port bundle and shared slave port of the bus arbiter
interface bus_arbiter_if
    import bus_pkg::*;
#(
    parameter int N_MASTERS = 2
) ();

    logic [N_MASTERS-1:0]        m_breq;
    logic [N_MASTERS-1:0]        m_bstart;
    logic [N_MASTERS-1:0]        m_ttype;
    logic [2*N_MASTERS-1:0]      m_tsize;
    logic [BUS_AW*N_MASTERS-1:0] m_addr;
    logic [BUS_DW*N_MASTERS-1:0] m_wdata;
    logic [N_MASTERS-1:0]        m_bgnt;
    logic [N_MASTERS-1:0]        m_bdone;
    logic [N_MASTERS-1:0]        m_berror;
    logic [BUS_DW-1:0]           m_rdata;

    logic                        s_bstart;
    logic                        s_ttype;
    logic [1:0]                  s_tsize;
    logic [BUS_AW-1:0]           s_addr;
    logic [BUS_DW-1:0]           s_wdata;
    logic                        s_bdone;
    logic                        s_berror;
    logic [BUS_DW-1:0]           s_rdata;

    // master: the arbiter, which owns the slave port; slave: the masters plus the slave device
    modport master (
        input  m_breq, m_bstart, m_ttype, m_tsize, m_addr, m_wdata,
        output m_bgnt, m_bdone, m_berror, m_rdata,
        output s_bstart, s_ttype, s_tsize, s_addr, s_wdata,
        input  s_bdone, s_berror, s_rdata
    );

    modport slave (
        output m_breq, m_bstart, m_ttype, m_tsize, m_addr, m_wdata,
        input  m_bgnt, m_bdone, m_berror, m_rdata,
        input  s_bstart, s_ttype, s_tsize, s_addr, s_wdata,
        output s_bdone, s_berror, s_rdata
    );

endinterface

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational round-robin pick: first requester at or after ptr, modulo N
module arb_rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    // First pass covers indices at/after the pointer, second pass wraps around to the rest.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid_o && req_i[i] && (PW'(i) >= ptr_i)) begin
                gnt_o[i] = 1'b1;
                idx_o    = PW'(i);
                valid_o  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid_o && req_i[i]) begin
                gnt_o[i] = 1'b1;
                idx_o    = PW'(i);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter sharing one slave bus between N masters, with watchdog abort
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTERS   = 2,
    parameter int PRIO_MASTER = 0,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);

    localparam int              PW      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int              WD_W    = (TO_W > 0) ? TO_W : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [PW-1:0]   PTR_RST = PW'(PRIO_MASTER);
    localparam logic [PW-1:0]   PTR_MAX = PW'(N_MASTERS - 1);

    arb_state_e           state_q, state_d;
    logic [N_MASTERS-1:0] bgnt_q, bgnt_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]      wd_q, wd_d;

    logic [N_MASTERS-1:0] pick_gnt;
    logic [PW-1:0]        pick_idx;
    logic                 pick_valid;

    logic                 own_breq;
    logic                 own_bstart;
    logic                 own_ttype;
    logic [1:0]           own_tsize;
    logic [BUS_AW-1:0]    own_addr;
    logic [BUS_DW-1:0]    own_wdata;
    logic                 wd_expire;
    logic [N_MASTERS-1:0] bdone;
    logic [N_MASTERS-1:0] berror;

    arb_rr_pick #(
        .N  (N_MASTERS),
        .PW (PW)
    ) u_pick (
        .req_i   (bus.m_breq),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // The registered one-hot grant doubles as the owner select, so no owner means all zeros.
    always_comb begin
        own_breq   = 1'b0;
        own_bstart = 1'b0;
        own_ttype  = 1'b0;
        own_tsize  = '0;
        own_addr   = '0;
        own_wdata  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (bgnt_q[i]) begin
                own_breq   = bus.m_breq[i];
                own_bstart = bus.m_bstart[i];
                own_ttype  = bus.m_ttype[i];
                own_tsize  = bus.m_tsize[i*2 +: 2];
                own_addr   = bus.m_addr[i*BUS_AW +: BUS_AW];
                own_wdata  = bus.m_wdata[i*BUS_DW +: BUS_DW];
            end
        end
    end

    assign wd_expire = (TIMEOUT > 0) && (state_q == BUSY) && (wd_q == WD_LAST);

    always_comb begin
        state_d  = state_q;
        bgnt_d   = bgnt_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        wd_d     = wd_q;
        bdone    = '0;
        berror   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    bgnt_d  = pick_gnt;
                    owner_d = pick_idx;
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                if (own_bstart) begin
                    wd_d    = '0;
                    state_d = BUSY;
                end else if (!own_breq) begin
                    bgnt_d  = '0;
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // Slave completion is checked first so a late bdone still beats the watchdog.
                if (bus.s_bdone || bus.s_berror) begin
                    bdone    = bus.s_bdone ? bgnt_q : '0;
                    berror   = bus.s_berror ? bgnt_q : '0;
                    rr_ptr_d = (owner_q == PTR_MAX) ? '0 : owner_q + PW'(1);
                    bgnt_d   = '0;
                    state_d  = IDLE;
                end else if (wd_expire) begin
                    berror  = bgnt_q;
                    bgnt_d  = '0;
                    state_d = IDLE;
                end else if (wd_q != WD_LAST) begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                bgnt_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bgnt_q   <= '0;
            owner_q  <= '0;
            rr_ptr_q <= PTR_RST;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            bgnt_q   <= bgnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            wd_q     <= wd_d;
        end
    end

    assign bus.m_bgnt   = bgnt_q;
    assign bus.m_bdone  = bdone;
    assign bus.m_berror = berror;
    assign bus.m_rdata  = bus.s_rdata;
    assign bus.s_bstart = own_bstart;
    assign bus.s_ttype  = own_ttype;
    assign bus.s_tsize  = own_tsize;
    assign bus.s_addr   = own_addr;
    assign bus.s_wdata  = own_wdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed scenarios plus randomized transactions against a reference model
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int N    = 2;
    localparam int PRIO = 0;
    localparam int TMO  = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.N_MASTERS(N)) bif ();

    bus_arbiter #(
        .N_MASTERS   (N),
        .PRIO_MASTER (PRIO),
        .TIMEOUT     (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bif.m_breq   = '0;
        bif.m_bstart = '0;
        bif.m_ttype  = '0;
        bif.m_tsize  = '0;
        bif.m_addr   = '0;
        bif.m_wdata  = '0;
        bif.s_bdone  = 1'b0;
        bif.s_berror = 1'b0;
        bif.s_rdata  = '0;
    endtask

    task automatic set_master(input int m, input logic bs, input logic tt, input logic [1:0] ts,
                              input logic [31:0] a, input logic [31:0] wd);
        bif.m_bstart[m]         = bs;
        bif.m_ttype[m]          = tt;
        bif.m_tsize[m*2 +: 2]   = ts;
        bif.m_addr[m*32 +: 32]  = a;
        bif.m_wdata[m*32 +: 32] = wd;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        mid();
        total++;
        if (bif.m_bgnt !== 2'b00) begin bad++; $display("FAIL reset_bgnt got=%b exp=00", bif.m_bgnt); end
        total++;
        if ({bif.s_bstart, bif.s_ttype, bif.s_tsize, bif.s_addr, bif.s_wdata} !== 68'd0) begin
            bad++; $display("FAIL reset_s_outputs got bstart=%b addr=%h wdata=%h exp all 0", bif.s_bstart, bif.s_addr, bif.s_wdata);
        end
        total++;
        if ({bif.m_bdone, bif.m_berror} !== 4'b0000) begin
            bad++; $display("FAIL reset_done_err got=%b/%b exp=00/00", bif.m_bdone, bif.m_berror);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_rr_write();
        bif.m_breq = 2'b11;
        mid();
        total++;
        if (bif.m_bgnt !== 2'b00) begin bad++; $display("FAIL t1_grant_latency got=%b exp=00", bif.m_bgnt); end
        step();
        set_master(0, 1'b1, WRITE, WORD, 32'h0000_0100, 32'hA5A5_0001);
        mid();
        total++;
        if (bif.m_bgnt !== 2'b01) begin bad++; $display("FAIL t1_prio_grant got=%b exp=01", bif.m_bgnt); end
        total++;
        if ({bif.s_bstart, bif.s_ttype, bif.s_tsize, bif.s_addr, bif.s_wdata} !== {1'b1, 1'b1, 2'd2, 32'h100, 32'hA5A5_0001}) begin
            bad++; $display("FAIL t1_forward got bstart=%b tt=%b ts=%0d addr=%h wd=%h exp 1/1/2/100/a5a50001",
                            bif.s_bstart, bif.s_ttype, bif.s_tsize, bif.s_addr, bif.s_wdata);
        end
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 3) bif.s_bdone = 1'b1;
            mid();
            total++;
            if (bif.m_bdone !== ((c == 3) ? 2'b01 : 2'b00)) begin
                bad++; $display("FAIL t1_bdone cycle=%0d got=%b exp=%b", c, bif.m_bdone, (c == 3) ? 2'b01 : 2'b00);
            end
        end
        step();
        bif.s_bdone = 1'b0;
        set_master(0, 1'b0, READ, BYTE, 32'h0, 32'h0);
        mid();
        total++;
        if (bif.m_bgnt !== 2'b00) begin bad++; $display("FAIL t1_idle_gap got=%b exp=00", bif.m_bgnt); end
    endtask

    task automatic test_read_second();
        step();
        set_master(1, 1'b1, READ, WORD, 32'h0, 32'h0);
        mid();
        total++;
        if (bif.m_bgnt !== 2'b10) begin bad++; $display("FAIL t2_rr_grant got=%b exp=10", bif.m_bgnt); end
        total++;
        if ({bif.s_bstart, bif.s_ttype, bif.s_addr} !== {1'b1, 1'b0, 32'h0}) begin
            bad++; $display("FAIL t2_forward got bstart=%b tt=%b addr=%h exp 1/0/0", bif.s_bstart, bif.s_ttype, bif.s_addr);
        end
        step();
        bif.s_rdata = 32'hDEAD_BEEF;
        bif.s_bdone = 1'b1;
        mid();
        total++;
        if (bif.m_bdone !== 2'b10) begin bad++; $display("FAIL t2_bdone got=%b exp=10", bif.m_bdone); end
        total++;
        if (bif.m_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL t2_rdata got=%h exp=deadbeef", bif.m_rdata); end
        step();
        clear_inputs();
        mid();
        total++;
        if (bif.m_bgnt !== 2'b00) begin bad++; $display("FAIL t2_release got=%b exp=00", bif.m_bgnt); end
    endtask

    task automatic test_timeout();
        step();
        bif.m_breq = 2'b01;
        step();
        set_master(0, 1'b1, WRITE, HALF, 32'h0000_0200, 32'h1234_5678);
        for (int c = 1; c <= TMO; c++) begin
            step();
            mid();
            total++;
            if ({bif.m_berror, bif.m_bdone} !== {((c == TMO) ? 2'b01 : 2'b00), 2'b00}) begin
                bad++; $display("FAIL t3_watchdog cycle=%0d got err=%b done=%b exp err=%b done=00",
                                c, bif.m_berror, bif.m_bdone, (c == TMO) ? 2'b01 : 2'b00);
            end
        end
        step();
        mid();
        total++;
        if ({bif.s_bstart, bif.m_bgnt, bif.m_berror} !== 5'b0) begin
            bad++; $display("FAIL t3_abort got bstart=%b gnt=%b err=%b exp 0/00/00", bif.s_bstart, bif.m_bgnt, bif.m_berror);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_done_at_timeout();
        bif.m_breq = 2'b10;
        step();
        set_master(1, 1'b1, READ, HALF, 32'h0000_0300, 32'h0);
        for (int c = 1; c <= TMO; c++) begin
            step();
            if (c == TMO) bif.s_bdone = 1'b1;
            mid();
            total++;
            if ({bif.m_bdone, bif.m_berror} !== {((c == TMO) ? 2'b10 : 2'b00), 2'b00}) begin
                bad++; $display("FAIL t4_done_beats_timeout cycle=%0d got done=%b err=%b exp done=%b err=00",
                                c, bif.m_bdone, bif.m_berror, (c == TMO) ? 2'b10 : 2'b00);
            end
        end
        step();
        clear_inputs();
    endtask

    task automatic test_drop_request();
        bif.m_breq = 2'b10;
        step();
        bif.m_breq = 2'b01;
        mid();
        total++;
        if ({bif.m_bgnt, bif.s_bstart} !== 3'b100) begin
            bad++; $display("FAIL t5_granted got gnt=%b bstart=%b exp 10/0", bif.m_bgnt, bif.s_bstart);
        end
        step();
        mid();
        total++;
        if ({bif.m_bgnt, bif.s_bstart} !== 3'b000) begin
            bad++; $display("FAIL t5_released got gnt=%b bstart=%b exp 00/0", bif.m_bgnt, bif.s_bstart);
        end
        step();
        bif.m_breq = 2'b00;
        mid();
        total++;
        if ({bif.m_bgnt, bif.s_bstart} !== 3'b010) begin
            bad++; $display("FAIL t5_pending_grant got gnt=%b bstart=%b exp 01/0", bif.m_bgnt, bif.s_bstart);
        end
        step();
        step();
    endtask

    task automatic test_async_reset();
        bif.m_breq = 2'b01;
        step();
        set_master(0, 1'b1, WRITE, WORD, 32'h0000_0400, 32'h0);
        step();
        bif.s_bdone = 1'b1;
        step();
        clear_inputs();
        bif.m_breq = 2'b11;
        step();
        set_master(1, 1'b1, WRITE, WORD, 32'h0000_0500, 32'hCAFE_0005);
        mid();
        total++;
        if (bif.m_bgnt !== 2'b10) begin bad++; $display("FAIL t6_rr_after_done got=%b exp=10", bif.m_bgnt); end
        step();
        mid();
        total++;
        if (bif.s_bstart !== 1'b1) begin bad++; $display("FAIL t6_busy_bstart got=%b exp=1", bif.s_bstart); end
        #1;
        rst = 1'b1;
        bif.s_bdone = 1'b1;
        #1;
        total++;
        if ({bif.m_bgnt, bif.s_bstart, bif.m_bdone, bif.s_addr} !== 37'd0) begin
            bad++; $display("FAIL t6_async_reset got gnt=%b bstart=%b done=%b addr=%h exp all 0",
                            bif.m_bgnt, bif.s_bstart, bif.m_bdone, bif.s_addr);
        end
        step();
        rst = 1'b0;
        clear_inputs();
        bif.m_breq = 2'b11;
        step();
        bif.m_breq = 2'b00;
        mid();
        total++;
        if (bif.m_bgnt !== 2'(1 << PRIO)) begin bad++; $display("FAIL t6_prio_after_reset got=%b exp=%b", bif.m_bgnt, 2'(1 << PRIO)); end
        step();
        step();
    endtask

    task automatic test_random();
        int model_ptr;
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_inputs();
        model_ptr = PRIO;
        for (int it = 0; it < 40; it++) begin
            logic [N-1:0] req;
            logic [N-1:0] exp_g;
            logic [N-1:0] exp_d;
            logic [N-1:0] exp_e;
            logic [31:0]  a;
            logic [31:0]  wd;
            logic [31:0]  rd;
            logic         tt;
            logic [1:0]   ts;
            int           w;
            int           lat;
            int           kind;
            int           last;
            req = N'($urandom_range(1, (1 << N) - 1));
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(model_ptr + k) % N]) w = (model_ptr + k) % N;
            end
            exp_g = N'(1) << w;
            bif.m_breq = req;
            mid();
            total++;
            if ({bif.m_bgnt, bif.s_bstart} !== {N'(0), 1'b0}) begin
                bad++; $display("FAIL rnd_idle it=%0d got gnt=%b bstart=%b exp 0/0", it, bif.m_bgnt, bif.s_bstart);
            end
            step();
            for (int o = 0; o < N; o++) begin
                if (o != w) set_master(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
            end
            a  = $urandom;
            wd = $urandom;
            tt = 1'($urandom_range(0, 1));
            ts = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) begin
                set_master(w, 1'b0, tt, ts, a, wd);
                bif.m_breq = '0;
                mid();
                total++;
                if ({bif.m_bgnt, bif.s_bstart} !== {exp_g, 1'b0}) begin
                    bad++; $display("FAIL rnd_drop it=%0d got gnt=%b bstart=%b exp %b/0", it, bif.m_bgnt, bif.s_bstart, exp_g);
                end
            end else begin
                set_master(w, 1'b1, tt, ts, a, wd);
                mid();
                total++;
                if ({bif.m_bgnt, bif.s_bstart, bif.s_ttype, bif.s_tsize, bif.s_addr, bif.s_wdata} !== {exp_g, 1'b1, tt, ts, a, wd}) begin
                    bad++; $display("FAIL rnd_grant_fwd it=%0d got gnt=%b bstart=%b tt=%b ts=%0d addr=%h wd=%h exp %b/1/%b/%0d/%h/%h",
                                    it, bif.m_bgnt, bif.s_bstart, bif.s_ttype, bif.s_tsize, bif.s_addr, bif.s_wdata,
                                    exp_g, tt, ts, a, wd);
                end
                lat  = $urandom_range(1, TMO + 1);
                kind = $urandom_range(0, 2);
                rd   = $urandom;
                last = (lat <= TMO) ? lat : TMO;
                for (int c = 1; c <= last; c++) begin
                    step();
                    if (c == lat) begin
                        bif.s_bdone  = (kind != 1);
                        bif.s_berror = (kind != 0);
                        bif.s_rdata  = rd;
                    end
                    exp_d = (c == lat && kind != 1) ? exp_g : '0;
                    exp_e = ((c == lat && kind != 0) || (lat > TMO && c == TMO)) ? exp_g : '0;
                    mid();
                    total++;
                    if ({bif.m_bgnt, bif.m_bdone, bif.m_berror, bif.s_addr} !== {exp_g, exp_d, exp_e, a}) begin
                        bad++; $display("FAIL rnd_busy it=%0d c=%0d got gnt=%b done=%b err=%b addr=%h exp %b/%b/%b/%h",
                                        it, c, bif.m_bgnt, bif.m_bdone, bif.m_berror, bif.s_addr, exp_g, exp_d, exp_e, a);
                    end
                    if (exp_d != '0) begin
                        total++;
                        if (bif.m_rdata !== rd) begin bad++; $display("FAIL rnd_rdata it=%0d got=%h exp=%h", it, bif.m_rdata, rd); end
                    end
                end
                if (lat <= TMO) model_ptr = (w + 1) % N;
            end
            step();
            clear_inputs();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout reached simulation time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rr_write();
        test_read_second();
        test_timeout();
        test_done_at_timeout();
        test_drop_request();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
